// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and the
// round-robin pointer wrap helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND_LO = 2'b01,
    ST_SEND_HI = 2'b10
  } arb_state_e;

  // Next round-robin index; wraps explicitly so a non-power-of-2 count never
  // produces an index past n-1.
  function automatic logic [31:0] rr_wrap_inc(input logic [31:0] idx,
                                              input logic [31:0] n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr,
// searching modulo NUM_REQ, reported as one-hot plus index.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [GNT_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_onehot_o,
  output logic [GNT_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic [31:0] cand;
  logic        found;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    found          = 1'b0;
    cand           = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {{(32-GNT_W){1'b0}}, rr_ptr_i} + 32'(k);
      if (cand >= 32'(NUM_REQ)) begin
        cand = cand - 32'(NUM_REQ);
      end
      if (!found && req_valid_i[cand[GNT_W-1:0]]) begin
        found                            = 1'b1;
        grant_onehot_o[cand[GNT_W-1:0]] = 1'b1;
        grant_idx_o                      = cand[GNT_W-1:0];
      end
    end
  end

  assign grant_valid_o = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port between NUM_REQ requesters; each granted
// 1- or 2-byte word is serialised LSB byte first under w_full backpressure.
//
// Handshakes: a requester word transfers on a CLK edge where req_valid[i] and
// req_ready[i] are both high; req_ready is one-hot and only asserted in IDLE.
// A FIFO byte is written on an edge where w_inc is high; w_inc is never high
// while w_full is high. Requesters hold data/two_byte stable until accepted.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 2,
  localparam int GNT_W      = $clog2(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_two_byte,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            w_full,
  output logic                            w_inc,
  output logic [DATA_WIDTH-1:0]           WR_DATA,
  output logic                            busy,
  output logic [GNT_W-1:0]                grant_id,
  output arb_state_e                      dbg_state_o
);

  localparam int WORD_W = 2 * DATA_WIDTH;

  arb_state_e          state_q;
  logic [WORD_W-1:0]   hold_q;
  logic                two_byte_q;
  logic [GNT_W-1:0]    rr_ptr_q;
  logic [GNT_W-1:0]    rr_ptr_d;
  logic [GNT_W-1:0]    grant_id_q;

  logic [NUM_REQ-1:0]  grant_onehot;
  logic [GNT_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [WORD_W-1:0]   sel_word;
  logic                sel_two_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_valid_i    (req_valid),
    .rr_ptr_i       (rr_ptr_q),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .grant_valid_o  (grant_valid)
  );

  always_comb begin
    sel_word     = '0;
    sel_two_byte = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == k[GNT_W-1:0]) begin
        sel_word     = req_data[k*WORD_W +: WORD_W];
        sel_two_byte = req_two_byte[k];
      end
    end
  end

  assign rr_ptr_d = GNT_W'(rr_wrap_inc(32'(grant_idx), 32'(NUM_REQ)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      two_byte_q <= 1'b0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            hold_q     <= sel_word;
            two_byte_q <= sel_two_byte;
            grant_id_q <= grant_idx;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (!w_full) begin
            state_q <= two_byte_q ? ST_SEND_HI : ST_IDLE;
          end
        end
        ST_SEND_HI: begin
          if (!w_full) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RST gates the combinational strobes so they drop the moment reset rises.
  assign req_ready   = (state_q == ST_IDLE && !RST) ? grant_onehot : '0;
  assign w_inc       = (state_q == ST_SEND_LO || state_q == ST_SEND_HI) && !w_full && !RST;
  assign WR_DATA     = (state_q == ST_SEND_HI) ? hold_q[WORD_W-1:DATA_WIDTH]
                                               : hold_q[DATA_WIDTH-1:0];
  assign busy        = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
  assign grant_id    = grant_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 2-requester and a 3-requester
// instance driven with directed words; monitors pop expected grants/bytes.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: NUM_REQ=2 ----------------
  logic [1:0]  rv_a, rt_a, rr_a;
  logic [31:0] rd_a;
  logic        wf_a, wi_a, busy_a;
  logic [7:0]  wd_a;
  logic [0:0]  gid_a;
  arb_state_e  st_a;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2)) dut_a (
    .CLK(clk), .RST(rst), .req_valid(rv_a), .req_data(rd_a),
    .req_two_byte(rt_a), .req_ready(rr_a), .w_full(wf_a), .w_inc(wi_a),
    .WR_DATA(wd_a), .busy(busy_a), .grant_id(gid_a), .dbg_state_o(st_a)
  );

  // ---------------- instance B: NUM_REQ=3 ----------------
  logic [2:0]  rv_b, rt_b, rr_b;
  logic [47:0] rd_b;
  logic        wf_b, wi_b, busy_b;
  logic [7:0]  wd_b;
  logic [1:0]  gid_b;
  arb_state_e  st_b;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3)) dut_b (
    .CLK(clk), .RST(rst), .req_valid(rv_b), .req_data(rd_b),
    .req_two_byte(rt_b), .req_ready(rr_b), .w_full(wf_b), .w_inc(wi_b),
    .WR_DATA(wd_b), .busy(busy_b), .grant_id(gid_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_byte_a[$];
  logic [7:0] exp_byte_b[$];
  logic [1:0] exp_gnt_a[$];
  logic [1:0] exp_gnt_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    for (int k = 0; k < 3; k++) begin
      if (oh[k]) return k[1:0];
    end
    return 2'd3;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rr_a != 2'b00) check("ready_onehot_a", $countones(rr_a), 1);
      if ((rv_a & rr_a) != 2'b00) begin
        if (exp_gnt_a.size() == 0) check("grant_pending_a", 0, 1);
        else check("grant_a", oh_idx({1'b0, rv_a & rr_a}), exp_gnt_a.pop_front());
      end
      if (wi_a) begin
        check("no_write_when_full_a", wf_a, 0);
        if (exp_byte_a.size() == 0) check("spurious_write_a", wd_a, 32'hFFFF_FFFF);
        else check("wr_byte_a", wd_a, exp_byte_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rr_b != 3'b000) check("ready_onehot_b", $countones(rr_b), 1);
      if ((rv_b & rr_b) != 3'b000) begin
        if (exp_gnt_b.size() == 0) check("grant_pending_b", 0, 1);
        else check("grant_b", oh_idx(rv_b & rr_b), exp_gnt_b.pop_front());
      end
      if (wi_b) begin
        check("no_write_when_full_b", wf_b, 0);
        if (exp_byte_b.size() == 0) check("spurious_write_b", wd_b, 32'hFFFF_FFFF);
        else check("wr_byte_b", wd_b, exp_byte_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 1ns after the accepting edge (word now in SEND_LO).
  task automatic send_a(input int idx, input logic [15:0] data, input logic two);
    int budget;
    rd_a[idx*16 +: 16] = data;
    rt_a[idx]          = two;
    rv_a[idx]          = 1'b1;
    budget = 50;
    do begin
      @(negedge clk);
      budget--;
    end while (!rr_a[idx] && budget > 0);
    if (!rr_a[idx]) check("accept_timeout_a", 0, 1);
    @(posedge clk); #1;
    rv_a[idx] = 1'b0;
  endtask

  task automatic wait_idle_a();
    int budget = 50;
    do begin
      @(negedge clk);
      budget--;
    end while (busy_a && budget > 0);
    if (busy_a) check("idle_timeout_a", busy_a, 0);
    @(posedge clk); #1;
  endtask

  // Raise every requester in mask; drop each once its transfer is seen.
  task automatic run_b(input logic [2:0] mask);
    logic [2:0] pending, xfer;
    int budget = 60;
    pending = mask;
    rv_b    = mask;
    while (pending != 3'b000 && budget > 0) begin
      @(negedge clk);
      xfer = rv_b & rr_b;
      @(posedge clk); #1;
      rv_b    = rv_b & ~xfer;
      pending = pending & ~xfer;
      budget--;
    end
    if (pending != 3'b000) check("accept_timeout_b", pending, 0);
  endtask

  task automatic wait_idle_b();
    int budget = 50;
    do begin
      @(negedge clk);
      budget--;
    end while (busy_b && budget > 0);
    if (busy_b) check("idle_timeout_b", busy_b, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt;
    int budget;
    rst = 1'b1;
    rv_a = '0; rt_a = '0; rd_a = '0; wf_a = 1'b0;
    rv_b = '0; rt_b = '0; rd_b = '0; wf_b = 1'b0;
    rv_a = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rr_a, 0);
    check("rst_winc", wi_a, 0);
    check("rst_wdata", wd_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_gid", gid_a, 0);
    check("rst_state", st_a, ST_IDLE);
    check("rst_gid_b", gid_b, 0);
    rv_a = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single 1-byte word
    exp_gnt_a.push_back(2'd0);
    exp_byte_a.push_back(8'hA5);
    send_a(0, 16'h12A5, 1'b0);
    check("t2_busy", busy_a, 1);
    check("t2_winc", wi_a, 1);
    check("t2_wdata", wd_a, 8'hA5);
    check("t2_gid", gid_a, 0);
    @(posedge clk); #1;
    check("t2_idle", st_a, ST_IDLE);
    check("t2_winc_off", wi_a, 0);

    // 2-byte word from requester 1
    exp_gnt_a.push_back(2'd1);
    exp_byte_a.push_back(8'hEF);
    exp_byte_a.push_back(8'hBE);
    send_a(1, 16'hBEEF, 1'b1);
    check("t3_gid", gid_a, 1);
    check("t3_lo", wd_a, 8'hEF);
    @(posedge clk); #1;
    check("t3_state_hi", st_a, ST_SEND_HI);
    check("t3_hi", wd_a, 8'hBE);
    check("t3_winc_hi", wi_a, 1);
    @(posedge clk); #1;
    check("t3_idle", busy_a, 0);

    // contention: both valid, grants must alternate 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      exp_gnt_a.push_back(2'd0);
      exp_gnt_a.push_back(2'd1);
      exp_byte_a.push_back(8'h11);
      exp_byte_a.push_back(8'h22);
    end
    rd_a = {16'h0022, 16'h0011};
    rt_a = 2'b00;
    rv_a = 2'b11;
    cnt = 0;
    budget = 40;
    while (cnt < 4 && budget > 0) begin
      @(negedge clk);
      if ((rv_a & rr_a) != 2'b00) cnt++;
      budget--;
    end
    check("t4_accepts", cnt, 4);
    @(posedge clk); #1;
    rv_a = 2'b00;
    wait_idle_a();

    // backpressure for 5 cycles in SEND_HI
    exp_gnt_a.push_back(2'd0);
    exp_byte_a.push_back(8'h4D);
    exp_byte_a.push_back(8'h3C);
    send_a(0, 16'h3C4D, 1'b1);
    @(posedge clk); #1;
    wf_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_winc_full", wi_a, 0);
      check("t5_wdata_stable", wd_a, 8'h3C);
      check("t5_hold_hi", st_a, ST_SEND_HI);
      @(posedge clk); #1;
    end
    wf_a = 1'b0;
    #1;
    check("t5_winc_release", wi_a, 1);
    wait_idle_a();

    // w_full toggling across both bytes of one word
    exp_gnt_a.push_back(2'd1);
    exp_byte_a.push_back(8'h69);
    exp_byte_a.push_back(8'h5A);
    send_a(1, 16'h5A69, 1'b1);
    wf_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("tg_hold_lo", st_a, ST_SEND_LO);
    wf_a = 1'b0;
    @(posedge clk); #1;
    wf_a = 1'b1;
    @(posedge clk); #1;
    check("tg_hold_hi", st_a, ST_SEND_HI);
    wf_a = 1'b0;
    wait_idle_a();

    // reset in SEND_HI: high byte must never be written
    exp_gnt_a.push_back(2'd0);
    exp_byte_a.push_back(8'hFE);
    send_a(0, 16'hCAFE, 1'b1);
    @(posedge clk); #1;
    check("t1_in_hi", st_a, ST_SEND_HI);
    rv_a[1] = 1'b1;
    rst = 1'b1;
    #1;
    check("t1_winc", wi_a, 0);
    check("t1_ready", rr_a, 0);
    check("t1_busy", busy_a, 0);
    check("t1_wdata", wd_a, 0);
    @(posedge clk); #1;
    rv_a = 2'b00;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("t1_stay_idle", busy_a, 0);

    // NUM_REQ=3: move rr_ptr to 2 via requester 1
    exp_gnt_b.push_back(2'd1);
    exp_byte_b.push_back(8'h01);
    rd_b[16 +: 16] = 16'h7701;
    rt_b = 3'b000;
    run_b(3'b010);
    wait_idle_b();
    check("t6_gid1", gid_b, 1);

    // rr_ptr=2, requesters 2 and 0: grant 2 then 0 (2-byte)
    exp_gnt_b.push_back(2'd2);
    exp_gnt_b.push_back(2'd0);
    exp_byte_b.push_back(8'hC2);
    exp_byte_b.push_back(8'hA0);
    exp_byte_b.push_back(8'hB0);
    rd_b[32 +: 16] = 16'h00C2;
    rd_b[0 +: 16]  = 16'hB0A0;
    rt_b = 3'b001;
    run_b(3'b101);
    wait_idle_b();
    check("t6_gid0", gid_b, 0);
    check("t6_gid_known", $isunknown(gid_b), 0);

    // rr_ptr=1 after wrap: requesters 2 and 0 -> grant 2 then 0
    exp_gnt_b.push_back(2'd2);
    exp_gnt_b.push_back(2'd0);
    exp_byte_b.push_back(8'h30);
    exp_byte_b.push_back(8'h10);
    rd_b[32 +: 16] = 16'h0030;
    rd_b[0 +: 16]  = 16'h0010;
    rt_b = 3'b000;
    run_b(3'b101);
    wait_idle_b();
    check("t6_gid_last", gid_b, 0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_empty_a", exp_byte_a.size() + exp_gnt_a.size(), 0);
    check("exp_empty_b", exp_byte_b.size() + exp_gnt_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
